// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// Circular in-order commit buffer. Each issued instruction takes the entry at
// the tail. Results arrive on the RS and LSB broadcast buses. At most one
// entry retires per cycle from the head. A mispredicted branch at the head
// flushes all speculative state and redirects fetch.
//
// Optional build macro: ROB_BYPASS_EN
//   defined   -> the operand queries also forward same-cycle RS/LSB broadcasts
//                (LSB has priority)
//   undefined -> the operand queries return stored state only
//
// Ports:
//   clockIn, resetIn                  clock, synchronous active-high reset
//   issueValid/Type/Dest/PredTaken/AltPc
//                                     allocate an entry at the tail
//   issueRobIndex, full               tag the next issue gets, buffer full
//   rsUpdate/RobIndex/UpdateVal       RS result broadcast
//   lsbUpdate/RobIndex/UpdateVal      LSB broadcast
//   queryN{Index,Ready,Val}           two combinational operand lookups
//   commitValid/Dest/Val/RobIndex     registered register-write retire pulse
//   storeCommit                       registered store retire pulse
//   flush, flushPc                    registered mispredict flush pulse and PC
// -----------------------------------------------------------------------------
module reorder_buffer #(
   parameter int ROB_WIDTH = 4,
   parameter int REG_WIDTH = 5
) (
   input  logic                 clockIn,
   input  logic                 resetIn,
   input  logic                 issueValid,
   input  logic [1:0]           issueType,
   input  logic [REG_WIDTH-1:0] issueDest,
   input  logic                 issuePredTaken,
   input  logic [31:0]          issueAltPc,
   output logic [ROB_WIDTH-1:0] issueRobIndex,
   output logic                 full,
   input  logic                 rsUpdate,
   input  logic [ROB_WIDTH-1:0] rsRobIndex,
   input  logic [31:0]          rsUpdateVal,
   input  logic                 lsbUpdate,
   input  logic [ROB_WIDTH-1:0] lsbRobIndex,
   input  logic [31:0]          lsbUpdateVal,
   input  logic [ROB_WIDTH-1:0] query1Index,
   output logic                 query1Ready,
   output logic [31:0]          query1Val,
   input  logic [ROB_WIDTH-1:0] query2Index,
   output logic                 query2Ready,
   output logic [31:0]          query2Val,
   output logic                 commitValid,
   output logic [REG_WIDTH-1:0] commitDest,
   output logic [31:0]          commitVal,
   output logic [ROB_WIDTH-1:0] commitRobIndex,
   output logic                 storeCommit,
   output logic                 flush,
   output logic [31:0]          flushPc
);

   localparam int DEPTH = 1 << ROB_WIDTH;

   // Type 2'b11 is reserved and retires exactly like a register write.
   typedef enum logic [1:0] {
      OP_REG    = 2'b00,
      OP_STORE  = 2'b01,
      OP_BRANCH = 2'b10,
      OP_RSVD   = 2'b11
   } op_e;

   typedef struct packed {
      logic                 ready;
      op_e                  op;
      logic [REG_WIDTH-1:0] dest;
      logic                 pred_taken;
      logic [31:0]          alt_pc;
      logic [31:0]          value;
   } entry_t;

   logic [DEPTH-1:0]     busy_q, busy_d;
   entry_t               entry_q [DEPTH];
   logic [ROB_WIDTH-1:0] head_q, head_d;
   logic [ROB_WIDTH-1:0] tail_q, tail_d;
   logic [ROB_WIDTH:0]   count_q, count_d;

   logic                 commit_valid_q;
   logic [REG_WIDTH-1:0] commit_dest_q;
   logic [31:0]          commit_val_q;
   logic [ROB_WIDTH-1:0] commit_idx_q;
   logic                 store_commit_q;
   logic                 flush_q;
   logic [31:0]          flush_pc_q;

   entry_t head_entry;
   logic   head_fire;
   logic   head_is_reg;
   logic   mispredict;
   logic   issue_accept;

   assign head_entry  = entry_q[head_q];
   assign head_fire   = busy_q[head_q] && head_entry.ready;
   assign head_is_reg = (head_entry.op == OP_REG) || (head_entry.op == OP_RSVD);
   assign mispredict  = head_fire && (head_entry.op == OP_BRANCH) &&
                        (head_entry.value[0] != head_entry.pred_taken);

   // Full is judged on the pre-commit count, so a same-cycle retire never
   // opens a slot for an issue; a mispredict drops the issue outright.
   assign full          = (count_q == (ROB_WIDTH+1)'(DEPTH));
   assign issue_accept  = issueValid && !full && !mispredict;
   assign issueRobIndex = tail_q;

   // NOTE: every variable gets a default at the top of an always_comb so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      busy_d  = busy_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + (ROB_WIDTH+1)'(issue_accept) - (ROB_WIDTH+1)'(head_fire);
      if (mispredict) begin
         busy_d  = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (head_fire) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + ROB_WIDTH'(1);
         end
         if (issue_accept) begin
            busy_d[tail_q] = 1'b1;
            tail_d         = tail_q + ROB_WIDTH'(1);
         end
      end
   end

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clockIn) begin
      if (resetIn) begin
         busy_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: the entry payload is deliberately not reset; the busy bits alone
   // decide whether an entry is live, so stale payload is never observed.
   always_ff @(posedge clockIn) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (issue_accept && (tail_q == ROB_WIDTH'(i))) begin
            entry_q[i] <= '{ready:      1'b0,
                            op:         op_e'(issueType),
                            dest:       issueDest,
                            pred_taken: issuePredTaken,
                            alt_pc:     issueAltPc,
                            value:      32'h0};
         end else if (busy_q[i] && !mispredict) begin
            // LSB is checked first so it wins a same-tag collision.
            if (lsbUpdate && (lsbRobIndex == ROB_WIDTH'(i))) begin
               entry_q[i].ready <= 1'b1;
               entry_q[i].value <= lsbUpdateVal;
            end else if (rsUpdate && (rsRobIndex == ROB_WIDTH'(i))) begin
               entry_q[i].ready <= 1'b1;
               entry_q[i].value <= rsUpdateVal;
            end
         end
      end
   end

   // Retire outputs are registered: they show up the cycle after the head
   // entry is seen ready.
   always_ff @(posedge clockIn) begin
      if (resetIn) begin
         commit_valid_q <= 1'b0;
         commit_dest_q  <= '0;
         commit_val_q   <= '0;
         commit_idx_q   <= '0;
         store_commit_q <= 1'b0;
         flush_q        <= 1'b0;
         flush_pc_q     <= '0;
      end else begin
         commit_valid_q <= head_fire && head_is_reg;
         store_commit_q <= head_fire && (head_entry.op == OP_STORE);
         flush_q        <= mispredict;
         if (head_fire && head_is_reg) begin
            commit_dest_q <= head_entry.dest;
            commit_val_q  <= head_entry.value;
            commit_idx_q  <= head_q;
         end
         if (mispredict) begin
            flush_pc_q <= head_entry.alt_pc;
         end
      end
   end

   assign commitValid    = commit_valid_q;
   assign commitDest     = commit_dest_q;
   assign commitVal      = commit_val_q;
   assign commitRobIndex = commit_idx_q;
   assign storeCommit    = store_commit_q;
   assign flush          = flush_q;
   assign flushPc        = flush_pc_q;

   // Returns {ready, value} for one operand lookup.
   function automatic logic [32:0] lookup(input logic [ROB_WIDTH-1:0] idx);
      logic [32:0] res;
      res = {busy_q[idx] && entry_q[idx].ready, entry_q[idx].value};
`ifdef ROB_BYPASS_EN
      if (busy_q[idx]) begin
         if (lsbUpdate && (lsbRobIndex == idx)) begin
            res = {1'b1, lsbUpdateVal};
         end else if (rsUpdate && (rsRobIndex == idx)) begin
            res = {1'b1, rsUpdateVal};
         end
      end
`endif
      return res;
   endfunction

   always_comb begin
      {query1Ready, query1Val} = lookup(query1Index);
      {query2Ready, query2Val} = lookup(query2Index);
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//
// Directed stimulus against reorder_buffer. A queue-based model of the
// in-flight instructions predicts every output; a negedge compare process
// checks the DUT against it each cycle, and the directed sequences add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

   logic        clockIn = 1'b0;
   logic        resetIn = 1'b1;
   logic        issueValid;
   logic [1:0]  issueType;
   logic [4:0]  issueDest;
   logic        issuePredTaken;
   logic [31:0] issueAltPc;
   logic [3:0]  issueRobIndex;
   logic        full;
   logic        rsUpdate;
   logic [3:0]  rsRobIndex;
   logic [31:0] rsUpdateVal;
   logic        lsbUpdate;
   logic [3:0]  lsbRobIndex;
   logic [31:0] lsbUpdateVal;
   logic [3:0]  query1Index;
   logic        query1Ready;
   logic [31:0] query1Val;
   logic [3:0]  query2Index;
   logic        query2Ready;
   logic [31:0] query2Val;
   logic        commitValid;
   logic [4:0]  commitDest;
   logic [31:0] commitVal;
   logic [3:0]  commitRobIndex;
   logic        storeCommit;
   logic        flush;
   logic [31:0] flushPc;

`ifdef ROB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   reorder_buffer #(.ROB_WIDTH(4), .REG_WIDTH(5)) dut (
      .clockIn        (clockIn),
      .resetIn        (resetIn),
      .issueValid     (issueValid),
      .issueType      (issueType),
      .issueDest      (issueDest),
      .issuePredTaken (issuePredTaken),
      .issueAltPc     (issueAltPc),
      .issueRobIndex  (issueRobIndex),
      .full           (full),
      .rsUpdate       (rsUpdate),
      .rsRobIndex     (rsRobIndex),
      .rsUpdateVal    (rsUpdateVal),
      .lsbUpdate      (lsbUpdate),
      .lsbRobIndex    (lsbRobIndex),
      .lsbUpdateVal   (lsbUpdateVal),
      .query1Index    (query1Index),
      .query1Ready    (query1Ready),
      .query1Val      (query1Val),
      .query2Index    (query2Index),
      .query2Ready    (query2Ready),
      .query2Val      (query2Val),
      .commitValid    (commitValid),
      .commitDest     (commitDest),
      .commitVal      (commitVal),
      .commitRobIndex (commitRobIndex),
      .storeCommit    (storeCommit),
      .flush          (flush),
      .flushPc        (flushPc)
   );

   always #5 clockIn = ~clockIn;

   int n_pass  = 0;
   int n_total = 0;
   bit armed   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- model: ordered list of in-flight instructions ----------
   typedef struct {
      logic [3:0]  tag;
      logic [1:0]  typ;
      logic [4:0]  dest;
      logic        pred;
      logic [31:0] alt;
      logic        rdy;
      logic [31:0] val;
   } m_ent_t;

   m_ent_t      mq[$];
   int          m_tail = 0;
   logic        exp_cv = 1'b0, exp_sc = 1'b0, exp_fl = 1'b0;
   logic [4:0]  exp_cd = '0;
   logic [31:0] exp_cval = '0, exp_fpc = '0;
   logic [3:0]  exp_cidx = '0;

   always @(posedge clockIn) begin
      bit fire, mis, was_full;
      m_ent_t e;
      if (resetIn) begin
         mq.delete();
         m_tail = 0;
         exp_cv = 1'b0; exp_sc = 1'b0; exp_fl = 1'b0;
      end else begin
         fire     = (mq.size() > 0) && mq[0].rdy;
         mis      = 1'b0;
         was_full = (mq.size() == 16);
         exp_cv = 1'b0; exp_sc = 1'b0; exp_fl = 1'b0;
         if (fire) begin
            case (mq[0].typ)
               2'b01: exp_sc = 1'b1;
               2'b10: if (mq[0].val[0] != mq[0].pred) begin
                         exp_fl = 1'b1; exp_fpc = mq[0].alt; mis = 1'b1;
                      end
               default: begin
                  exp_cv = 1'b1; exp_cd = mq[0].dest;
                  exp_cval = mq[0].val; exp_cidx = mq[0].tag;
               end
            endcase
         end
         if (mis) begin
            mq.delete();
            m_tail = 0;
         end else begin
            foreach (mq[i]) begin
               if (rsUpdate && mq[i].tag == rsRobIndex) begin
                  mq[i].rdy = 1'b1; mq[i].val = rsUpdateVal;
               end
            end
            foreach (mq[i]) begin
               if (lsbUpdate && mq[i].tag == lsbRobIndex) begin
                  mq[i].rdy = 1'b1; mq[i].val = lsbUpdateVal;
               end
            end
            if (fire) void'(mq.pop_front());
            if (issueValid && !was_full) begin
               e.tag = 4'(m_tail); e.typ = issueType; e.dest = issueDest;
               e.pred = issuePredTaken; e.alt = issueAltPc;
               e.rdy = 1'b0; e.val = '0;
               mq.push_back(e);
               m_tail = (m_tail + 1) % 16;
            end
         end
      end
   end

   function automatic void m_query(input logic [3:0] idx, output logic r, output logic [31:0] v);
      r = 1'b0; v = '0;
      foreach (mq[i]) begin
         if (mq[i].tag == idx) begin
            r = mq[i].rdy; v = mq[i].val;
            if (BYP && lsbUpdate && lsbRobIndex == idx) begin
               r = 1'b1; v = lsbUpdateVal;
            end else if (BYP && rsUpdate && rsRobIndex == idx) begin
               r = 1'b1; v = rsUpdateVal;
            end
         end
      end
   endfunction

   // ---------------- per-cycle compare against the model ------------------
   always @(negedge clockIn) begin
      logic        r;
      logic [31:0] v;
      if (armed) begin
         check("commitValid", 32'(commitValid), 32'(exp_cv));
         if (exp_cv) begin
            check("commitDest", 32'(commitDest), 32'(exp_cd));
            check("commitVal", commitVal, exp_cval);
            check("commitRobIndex", 32'(commitRobIndex), 32'(exp_cidx));
         end
         check("storeCommit", 32'(storeCommit), 32'(exp_sc));
         check("flush", 32'(flush), 32'(exp_fl));
         if (exp_fl) check("flushPc", flushPc, exp_fpc);
         check("full", 32'(full), 32'(mq.size() == 16));
         check("issueRobIndex", 32'(issueRobIndex), 32'(m_tail));
         m_query(query1Index, r, v);
         check("query1Ready", 32'(query1Ready), 32'(r));
         if (r) check("query1Val", query1Val, v);
         m_query(query2Index, r, v);
         check("query2Ready", 32'(query2Ready), 32'(r));
         if (r) check("query2Val", query2Val, v);
      end
   end

   // ---------------- stimulus helpers ---------------------------------------
   task automatic idle();
      issueValid = 0; issueType = 0; issueDest = 0; issuePredTaken = 0; issueAltPc = 0;
      rsUpdate = 0; rsRobIndex = 0; rsUpdateVal = 0;
      lsbUpdate = 0; lsbRobIndex = 0; lsbUpdateVal = 0;
      query1Index = 0; query2Index = 0;
   endtask

   task automatic tick();
      @(posedge clockIn);
      #1;
      idle();
   endtask

   task automatic do_reset();
      resetIn = 1'b1;
      tick();
      tick();
      resetIn = 1'b0;
   endtask

   task automatic issue(input logic [1:0] t, input logic [4:0] d, input logic p, input logic [31:0] alt);
      issueValid = 1'b1; issueType = t; issueDest = d; issuePredTaken = p; issueAltPc = alt;
   endtask

   task automatic rs(input logic [3:0] tag, input logic [31:0] val);
      rsUpdate = 1'b1; rsRobIndex = tag; rsUpdateVal = val;
   endtask

   task automatic lsb(input logic [3:0] tag, input logic [31:0] val);
      lsbUpdate = 1'b1; lsbRobIndex = tag; lsbUpdateVal = val;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      resetIn = 1'b1;
      tick();
      armed = 1'b1;
      do_reset();

      // Reset state.
      check("rst_full", 32'(full), 0);
      check("rst_issueRobIndex", 32'(issueRobIndex), 0);
      check("rst_commitValid", 32'(commitValid), 0);
      check("rst_flush", 32'(flush), 0);
      check("rst_storeCommit", 32'(storeCommit), 0);

      // Basic REG retire with two-cycle update-to-commit latency.
      issue(2'b00, 5'd5, 1'b0, 32'h0); tick();
      rs(4'd0, 32'h1234); tick();
      check("t1_no_commit_yet", 32'(commitValid), 0);
      tick();
      check("t1_commitValid", 32'(commitValid), 1);
      check("t1_commitDest", 32'(commitDest), 5);
      check("t1_commitVal", commitVal, 32'h1234);
      check("t1_commitRobIndex", 32'(commitRobIndex), 0);
      tick();
      check("t1_pulse_end", 32'(commitValid), 0);

      // Fill to 16, reject 17th, reject issue during the freeing commit, wrap.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         issue(2'b00, 5'(i), 1'b0, 32'h0); tick();
      end
      check("t2_full", 32'(full), 1);
      check("t2_tail_wrapped", 32'(issueRobIndex), 0);
      issue(2'b00, 5'd17, 1'b0, 32'h0); tick();
      check("t2_17th_ignored_tail", 32'(issueRobIndex), 0);
      check("t2_17th_still_full", 32'(full), 1);
      rs(4'd0, 32'hAA); tick();
      issue(2'b00, 5'd20, 1'b0, 32'h0); tick();
      check("t2_commit_at_full", 32'(commitValid), 1);
      check("t2_commitVal", commitVal, 32'hAA);
      check("t2_issue_rejected_tail", 32'(issueRobIndex), 0);
      check("t2_not_full_after_commit", 32'(full), 0);
      issue(2'b00, 5'd21, 1'b0, 32'h0); tick();
      check("t2_wrap_accepted", 32'(issueRobIndex), 1);
      check("t2_full_again", 32'(full), 1);

      // Out-of-order completion, in-order retire; LSB wins a tag collision.
      do_reset();
      issue(2'b00, 5'd1, 1'b0, 32'h0); tick();
      issue(2'b00, 5'd2, 1'b0, 32'h0); tick();
      rs(4'd1, 32'h22); tick();
      tick();
      check("t3_blocked_by_head", 32'(commitValid), 0);
      rs(4'd0, 32'h99); lsb(4'd0, 32'h11); tick();
      tick();
      check("t3_first_valid", 32'(commitValid), 1);
      check("t3_first_dest", 32'(commitDest), 1);
      check("t3_lsb_priority", commitVal, 32'h11);
      check("t3_first_idx", 32'(commitRobIndex), 0);
      tick();
      check("t3_second_valid", 32'(commitValid), 1);
      check("t3_second_dest", 32'(commitDest), 2);
      check("t3_second_val", commitVal, 32'h22);
      check("t3_second_idx", 32'(commitRobIndex), 1);

      // Mispredict flush with younger ready entries and a same-cycle issue.
      do_reset();
      issue(2'b10, 5'd0, 1'b0, 32'h100); tick();
      issue(2'b00, 5'd3, 1'b0, 32'h0); tick();
      issue(2'b00, 5'd4, 1'b0, 32'h0); tick();
      issue(2'b01, 5'd0, 1'b0, 32'h0); tick();
      rs(4'd1, 32'h5); lsb(4'd3, 32'h6); tick();
      rs(4'd2, 32'h7); tick();
      rs(4'd0, 32'h1); tick();
      issue(2'b00, 5'd9, 1'b0, 32'h0); tick();
      check("t4_flush", 32'(flush), 1);
      check("t4_flushPc", flushPc, 32'h100);
      check("t4_full", 32'(full), 0);
      check("t4_tail_reset_issue_dropped", 32'(issueRobIndex), 0);
      check("t4_no_commit", 32'(commitValid), 0);
      tick();
      check("t4_flush_pulse_end", 32'(flush), 0);
      check("t4_younger_no_commit", 32'(commitValid), 0);
      check("t4_younger_no_store", 32'(storeCommit), 0);
      // Correctly predicted branch retires silently.
      issue(2'b10, 5'd0, 1'b1, 32'h200); tick();
      rs(4'd0, 32'h3); tick();
      tick();
      check("t4_correct_no_flush", 32'(flush), 0);
      check("t4_tail_after_branch", 32'(issueRobIndex), 1);

      // Store retire.
      do_reset();
      issue(2'b01, 5'd0, 1'b0, 32'h0); tick();
      lsb(4'd0, 32'h40); tick();
      tick();
      check("t5_storeCommit", 32'(storeCommit), 1);
      check("t5_no_commitValid", 32'(commitValid), 0);
      tick();
      check("t5_store_pulse_end", 32'(storeCommit), 0);

      // Query and same-cycle bypass behaviour.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         issue(2'b00, 5'(i + 8), 1'b0, 32'h0); tick();
      end
      rs(4'd3, 32'd7); query1Index = 4'd3; query2Index = 4'd2;
      #1;
      check("t6_q1_same_cycle_ready", 32'(query1Ready), 32'(BYP));
      if (BYP) check("t6_q1_bypass_val", query1Val, 32'd7);
      check("t6_q2_not_ready", 32'(query2Ready), 0);
      tick();
      query1Index = 4'd3;
      #1;
      check("t6_q1_next_ready", 32'(query1Ready), 1);
      check("t6_q1_next_val", query1Val, 32'd7);
      query1Index = 4'd5;
      #1;
      check("t6_q1_not_busy", 32'(query1Ready), 0);
      tick();

      // Reset in the cycle a commit would fire suppresses it.
      do_reset();
      issue(2'b00, 5'd6, 1'b0, 32'h0); tick();
      rs(4'd0, 32'h66); tick();
      resetIn = 1'b1; tick();
      check("t7_no_commit_on_reset", 32'(commitValid), 0);
      resetIn = 1'b0; tick();
      check("t7_no_commit_after_reset", 32'(commitValid), 0);
      check("t7_empty_after_reset", 32'(issueRobIndex), 0);
      tick();

      armed = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
